// File: rtl/cv32e40p_register_file_mp.sv
// Parametrised multi-port flip-flop register file with a per-word pending-write scoreboard and a
// sequenced clear engine. Define CV32E40P_RF_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module cv32e40p_register_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 3,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_READ-1:0]              rbusy_o,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WRITE-1:0]             we_i,
    input  logic                             rsv_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    input  logic                             clear_req_i,
    output logic                             clear_busy_o,
    output logic                             clear_done_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam bit HAS_ZERO  = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = HAS_ZERO ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  busy_q, busy_d;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_busy;

    function automatic logic is_zero_word(input logic [ADDR_WIDTH-1:0] addr);
        return HAS_ZERO && (addr == '0);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                // Ascending port order lets the highest-index matching port overwrite the others.
                for (int q = 0; q < NUM_WRITE; q++) begin
                    if (we_i[q] && !is_zero_word(waddr_i[q*ADDR_WIDTH +: ADDR_WIDTH])) begin
                        mem_d[waddr_i[q*ADDR_WIDTH +: ADDR_WIDTH]]  = wdata_i[q*DATA_WIDTH +: DATA_WIDTH];
                        busy_d[waddr_i[q*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
                    end
                end
                if (rsv_i && !is_zero_word(rsv_addr_i)) begin
                    busy_d[rsv_addr_i] = 1'b1;
                end
                if (clear_req_i) begin
                    state_d = CLEAR;
                    idx_d   = FIRST_IDX;
                end
            end
            CLEAR: begin
                mem_d[idx_q]  = '0;
                busy_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            // NOTE: the array is reset because an all-zero register file after reset is visible to software.
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        rd_addr = '0;
        rd_word = '0;
        rd_busy = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word = mem_q[rd_addr];
            rd_busy = busy_q[rd_addr];
`ifdef CV32E40P_RF_WRITE_BYPASS_EN
            if (state_q == IDLE && !is_zero_word(rd_addr)) begin
                for (int q = 0; q < NUM_WRITE; q++) begin
                    if (we_i[q] && waddr_i[q*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr) begin
                        rd_word = wdata_i[q*DATA_WIDTH +: DATA_WIDTH];
                        if (!(rsv_i && rsv_addr_i == rd_addr)) begin
                            rd_busy = 1'b0;
                        end
                    end
                end
            end
`else
            // Registered contents only: a write is seen on the cycle after its edge.
`endif
            if (is_zero_word(rd_addr)) begin
                rd_word = '0;
                rd_busy = 1'b0;
            end
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_word;
            rbusy_o[p]                          = rd_busy;
        end
    end

    assign clear_busy_o = (state_q != IDLE);
    assign clear_done_o = (state_q == DONE);

endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Scoreboard bench for cv32e40p_register_file_mp: stimulus pushes expectations from an array model,
// a monitor pops and compares them mid-cycle.
module tb_cv32e40p_register_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int NWORDS = 32;
    localparam int ZR = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    we;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic             clear_req;
    logic             clear_busy;
    logic             clear_done;

    always #5 clk = ~clk;

    cv32e40p_register_file_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_i(rsv), .rsv_addr_i(rsv_addr),
        .clear_req_i(clear_req), .clear_busy_o(clear_busy), .clear_done_o(clear_done)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rbusy;
        logic             cb;
        logic             cd;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // Reference model: contents, busy flags, and the number of cycles spent in the clear sequence.
    logic [DW-1:0] m_mem [NWORDS];
    bit            m_busy [NWORDS];
    int            clr_cnt;

    int n_vec = 0;
    int n_miss = 0;

    task automatic model_reset();
        for (int i = 0; i < NWORDS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        clr_cnt = 0;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        int a;
        logic [DW-1:0] d;
        bit b;
        e.cb = (clr_cnt != 0);
        e.cd = (clr_cnt == NWORDS - ZR + 1);
        e.rdata = '0;
        e.rbusy = '0;
        for (int p = 0; p < NR; p++) begin
            a = int'(raddr[p*AW +: AW]);
            d = m_mem[a];
            b = m_busy[a];
`ifdef CV32E40P_RF_WRITE_BYPASS_EN
            if (!e.cb && !(ZR == 1 && a == 0)) begin
                for (int q = 0; q < NW; q++) begin
                    if (we[q] && int'(waddr[q*AW +: AW]) == a) begin
                        d = wdata[q*DW +: DW];
                        if (!(rsv && int'(rsv_addr) == a)) b = 1'b0;
                    end
                end
            end
`endif
            if (ZR == 1 && a == 0) begin
                d = '0;
                b = 1'b0;
            end
            e.rdata[p*DW +: DW] = d;
            e.rbusy[p] = b;
        end
        return e;
    endfunction

    // Applies the effect of one clock edge, using the inputs that were stable across it.
    task automatic model_edge();
        int a;
        if (!rst_n) return;
        if (clr_cnt != 0) begin
            if (clr_cnt <= NWORDS - ZR) begin
                a = ZR + clr_cnt - 1;
                m_mem[a]  = '0;
                m_busy[a] = 1'b0;
                clr_cnt++;
            end else begin
                clr_cnt = 0;
            end
        end else begin
            for (int q = 0; q < NW; q++) begin
                a = int'(waddr[q*AW +: AW]);
                if (we[q] && !(ZR == 1 && a == 0)) begin
                    m_mem[a]  = wdata[q*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (rsv && !(ZR == 1 && rsv_addr == '0)) m_busy[int'(rsv_addr)] = 1'b1;
            if (clear_req) clr_cnt = 1;
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic apply(input string tag);
        exp_q.push_back(expect_now());
        tag_q.push_back(tag);
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle_inputs();
        we = '0;
        waddr = '0;
        wdata = '0;
        rsv = 1'b0;
        rsv_addr = '0;
        clear_req = 1'b0;
    endtask

    task automatic set_raddr(input int a0, input int a1, input int a2);
        raddr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NWORDS - 1));
    endfunction

    task automatic random_inputs();
        for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = pick_addr();
        for (int q = 0; q < NW; q++) begin
            we[q] = 1'($urandom_range(0, 1));
            waddr[q*AW +: AW] = pick_addr();
            wdata[q*DW +: DW] = $urandom;
        end
        rsv = ($urandom_range(0, 3) == 0);
        rsv_addr = pick_addr();
        clear_req = ($urandom_range(0, 99) == 0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NWORDS; a += NR) begin
            next();
            idle_inputs();
            set_raddr(a % NWORDS, (a + 1) % NWORDS, (a + 2) % NWORDS);
            apply(tag);
        end
    endtask

    // Monitor: the DUT presents a read result every cycle; sample it mid-cycle.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_vec++;
                if ({rdata, rbusy, clear_busy, clear_done} !== e) begin
                    n_miss++;
                    $display("FAIL %s: got rdata=%h rbusy=%b cb=%b cd=%b, want rdata=%h rbusy=%b cb=%b cd=%b",
                             t, rdata, rbusy, clear_busy, clear_done, e.rdata, e.rbusy, e.cb, e.cd);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        raddr = '0;
        model_reset();

        next(); rst_n = 1'b0; model_reset(); set_raddr(0, 5, 31); apply("reset_hold");
        next(); rst_n = 1'b1; apply("reset_release");
        read_all("reset_read");

        next(); we = 2'b11; waddr = {AW'(5), AW'(5)}; wdata = {32'hBBBB0000, 32'hAAAA0000};
        set_raddr(5, 5, 5); apply("dual_write_addr5");
        next(); idle_inputs(); apply("port1_wins");
        next(); we = 2'b01; waddr = {AW'(0), AW'(0)}; wdata = {32'h0, 32'hFFFFFFFF};
        set_raddr(0, 5, 0); apply("write_word0");
        next(); idle_inputs(); apply("word0_reads_zero");

        next(); rsv = 1'b1; rsv_addr = AW'(7); set_raddr(7, 7, 0); apply("reserve7");
        next(); idle_inputs(); apply("busy7");
        next(); we = 2'b01; waddr = {AW'(0), AW'(7)}; wdata = {32'h0, 32'h1234}; apply("write7");
        next(); idle_inputs(); apply("write7_clears_busy");
        next(); we = 2'b10; waddr = {AW'(9), AW'(0)}; wdata = {32'h5555, 32'h0};
        rsv = 1'b1; rsv_addr = AW'(9); set_raddr(9, 9, 9); apply("reserve_and_write9");
        next(); idle_inputs(); apply("reserve_wins9");

        repeat (400) begin
            next(); random_inputs(); apply("random");
        end
        for (int i = 0; i < NWORDS + 4 && clr_cnt != 0; i++) begin
            next(); idle_inputs(); apply("drain_clear");
        end

        // Fill every register (reserving each one too), then clear the whole file.
        for (int i = 1; i < NWORDS; i++) begin
            next(); idle_inputs();
            we = 2'b01; waddr = {AW'(0), AW'(i)}; wdata = {32'h0, 32'(32'h10 + i)};
            rsv = 1'b1; rsv_addr = AW'((i + 1) % NWORDS);
            set_raddr(i - 1, i, (i + 5) % NWORDS); apply("fill");
        end
        read_all("fill_read");
        next(); idle_inputs(); clear_req = 1'b1; set_raddr(1, 2, 31); apply("clear_request");
        for (int k = 1; k <= NWORDS - ZR + 1; k++) begin
            next(); random_inputs(); we = 2'b11; clear_req = ($urandom_range(0, 1) == 1);
            apply("clear_window");
        end
        read_all("post_clear_read");

        // Clear interrupted by reset partway through.
        for (int i = 18; i < 26; i++) begin
            next(); idle_inputs();
            we = 2'b01; waddr = {AW'(0), AW'(i)}; wdata = {32'h0, 32'($urandom)};
            rsv = 1'b1; rsv_addr = AW'(i - 1);
            apply("prefill");
        end
        next(); idle_inputs(); clear_req = 1'b1; set_raddr(20, 21, 25); apply("clear_request2");
        for (int k = 1; k < 10; k++) begin
            next(); idle_inputs(); apply("clear_running");
        end
        next(); idle_inputs(); rst_n = 1'b0; model_reset(); apply("reset_mid_clear");
        next(); rst_n = 1'b1; apply("after_reset");
        read_all("post_reset_read");
        repeat (30) begin
            next(); idle_inputs(); set_raddr(20, 21, 25); apply("no_done_pulse");
        end

        // Same-cycle write/read of the same address; the model decides whether bypass applies.
        next(); idle_inputs(); we = 2'b01; waddr = {AW'(0), AW'(3)}; wdata = {32'h0, 32'h1111};
        set_raddr(3, 0, 3); apply("prewrite3");
        next(); idle_inputs(); we = 2'b01; waddr = {AW'(0), AW'(3)}; wdata = {32'h0, 32'hCAFE};
        set_raddr(3, 3, 3); apply("same_cycle_write3");
        next(); idle_inputs(); apply("next_cycle_read3");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL monitor_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
